// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, waits for and qualifies lock, then
// releases the clkin-domain system reset. Keeps saturating loss/timeout counters.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RST_HOLD_CYCLES     = 64
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       clear_counts,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked_ok,
  output logic [2:0] state,
  output logic [7:0] loss_count,
  output logic [7:0] timeout_count
);

  localparam int unsigned MaxAb = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCd = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                  LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned MaxCount = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW = $clog2(MaxCount) + 1;

  // Terminal values: the Nth edge in a state is the one seen with count N-1.
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StHold     = 3'd3,
    StRun      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              lock_s;
  logic              loss_inc, timeout_inc;
  logic              pll_reset_q, sys_reset_q, locked_ok_q;
  logic [7:0]        loss_q, loss_d, timeout_q, timeout_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  function automatic logic [7:0] next_count(input logic [7:0] cur, input logic inc,
                                            input logic clr);
    logic [7:0] res;
    res = cur;
    if (clr) begin
      res = inc ? 8'd1 : 8'd0;
    end else if (inc && (cur != 8'hff)) begin
      res = cur + 8'd1;
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StPllRst;
          timeout_inc = 1'b1;
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d  = StPllRst;
          loss_inc = 1'b1;
        end
      end
      default: state_d = StPllRst;
    endcase
  end

  // RUN has no terminal count, so the counter is parked there instead of wrapping.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || (state_q == StRun)) cnt_d = '0;
  end

  always_comb begin
    loss_d    = next_count(loss_q, loss_inc, clear_counts);
    timeout_d = next_count(timeout_q, timeout_inc, clear_counts);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_ok_q <= 1'b0;
      loss_q      <= 8'd0;
      timeout_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], lock};
      pll_reset_q <= (state_d == StPllRst);
      sys_reset_q <= (state_d != StRun);
      locked_ok_q <= (state_d == StRun);
      loss_q      <= loss_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state         = state_q;
  assign pll_reset     = pll_reset_q;
  assign sys_reset     = sys_reset_q;
  assign locked_ok     = locked_ok_q;
  assign loss_count    = loss_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed timing steps plus random lock/clear/reset
// traffic, all compared every cycle against an elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int SYNC = 2;
  localparam int PRST = 4;
  localparam int TMO  = 32;
  localparam int STB  = 8;
  localparam int HLD  = 4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       lock = 1'b1;
  logic       clear_counts = 1'b0;
  logic       pll_reset, sys_reset, locked_ok;
  logic [2:0] state;
  logic [7:0] loss_count, timeout_count;

  int tests = 0;
  int fails = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES        (SYNC),
    .PLL_RST_CYCLES     (PRST),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STB),
    .RST_HOLD_CYCLES    (HLD)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .lock         (lock),
    .clear_counts (clear_counts),
    .pll_reset    (pll_reset),
    .sys_reset    (sys_reset),
    .locked_ok    (locked_ok),
    .state        (state),
    .loss_count   (loss_count),
    .timeout_count(timeout_count)
  );

  always #5 clkin = ~clkin;

  // Reference model: phase number, edge index of phase entry, lock history queue.
  int edge_no = 0;
  int m_phase = 0;
  int m_entry = 0;
  int m_loss  = 0;
  int m_tmo   = 0;
  bit m_hist[$];

  function automatic int upd(input int cur, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc) return (cur + 1 > 255) ? 255 : cur + 1;
    return cur;
  endfunction

  task automatic model_step(input bit l, input bit r, input bit c);
    int k, nxt;
    bit ls, loss, tmo;
    edge_no++;
    if (r) begin
      m_phase = 0;
      m_entry = edge_no;
      m_loss  = 0;
      m_tmo   = 0;
      m_hist  = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    end else begin
      ls   = m_hist[SYNC-1];
      k    = edge_no - m_entry;
      nxt  = m_phase;
      loss = 1'b0;
      tmo  = 1'b0;
      case (m_phase)
        0: if (k == PRST) nxt = 1;
        1: if (ls) nxt = 2; else if (k == TMO) begin nxt = 0; tmo = 1'b1; end
        2: if (!ls) nxt = 1; else if (k == STB) nxt = 3;
        3: if (!ls) nxt = 1; else if (k == HLD) nxt = 4;
        default: if (!ls) begin nxt = 0; loss = 1'b1; end
      endcase
      if (nxt != m_phase) begin
        m_phase = nxt;
        m_entry = edge_no;
      end
      m_loss = upd(m_loss, loss, c);
      m_tmo  = upd(m_tmo, tmo, c);
      m_hist.push_front(l);
      m_hist = m_hist[0:SYNC-1];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    model_step(lock, reset, clear_counts);
    @(negedge clkin);
    check("state", 32'(state), 32'(m_phase));
    check("pll_reset", 32'(pll_reset), 32'(m_phase == 0));
    check("sys_reset", 32'(sys_reset), 32'(m_phase != 4));
    check("locked_ok", 32'(locked_ok), 32'(m_phase == 4));
    check("loss_count", 32'(loss_count), 32'(m_loss));
    check("timeout_count", 32'(timeout_count), 32'(m_tmo));
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  initial begin
    int fall, cnt, len;

    // Power-up with lock high throughout; edge 0 is the last reset edge.
    tick();
    check("reset_state", 32'(state), 0);
    check("reset_sys", 32'(sys_reset), 1);
    reset = 1'b0;
    fall = 0;
    for (int n = 1; n <= 100 && fall == 0; n++) begin
      tick();
      if (n == 3) check("pll_rst_high_e3", 32'(pll_reset), 1);
      if (n == 4) check("pll_rst_low_e4", 32'(pll_reset), 0);
      if (n == 5) check("stable_e5", 32'(state), 2);
      if (sys_reset === 1'b0) fall = n;
    end
    check("sys_reset_fall_edge", fall, 17);
    check("powerup_locked_ok", 32'(locked_ok), 1);

    // One-cycle lock glitch while in STABLE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_state(3'd2, 20, "reach_stable");
    repeat (3) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    wait_state(3'd1, 10, "glitch_wait_lock");
    wait_state(3'd2, 10, "glitch_restable");
    cnt = 0;
    while (state !== 3'd4 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("glitch_requal_len", cnt, STB + HLD);
    check("glitch_loss", 32'(loss_count), 0);
    check("glitch_tmo", 32'(timeout_count), 0);

    // Lock loss in RUN, then loss coinciding with clear, then clear alone.
    lock = 1'b0;
    tick();
    tick();
    check("loss_still_run", 32'(state), 4);
    tick();
    check("loss_state", 32'(state), 0);
    check("loss_count_1", 32'(loss_count), 1);
    lock = 1'b1;
    wait_state(3'd4, 100, "relock_run");
    lock = 1'b0;
    tick();
    tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    check("clear_with_inc", 32'(loss_count), 1);
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    check("clear_alone", 32'(loss_count), 0);

    // Another loss so counters are non-zero, then reset mid-HOLD.
    lock = 1'b1;
    wait_state(3'd4, 100, "relock_run2");
    lock = 1'b0;
    repeat (3) tick();
    lock = 1'b1;
    wait_state(3'd3, 100, "reach_hold");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midhold_state", 32'(state), 0);
    check("midhold_pll", 32'(pll_reset), 1);
    check("midhold_sys", 32'(sys_reset), 1);
    check("midhold_loss", 32'(loss_count), 0);
    wait_state(3'd4, 100, "rerun_after_reset");

    // Lock never arrives: retries every PRST+TMO cycles until the counter saturates.
    lock = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat ((PRST + TMO) * 2) tick();
    check("tmo_after_2", 32'(timeout_count), 2);
    repeat ((PRST + TMO) * 256) tick();
    check("tmo_saturated", 32'(timeout_count), 255);

    // Random lock segments with sporadic clears and resets.
    for (int seg = 0; seg < 80; seg++) begin
      lock = 1'($urandom_range(0, 1));
      len  = lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        clear_counts = ($urandom_range(0, 15) == 0);
        reset        = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    clear_counts = 1'b0;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
